// File: rtl/mux_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_rr_arb: registered N-channel selector, fixed-select or round-robin   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mux_rr_arb #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
  input  logic [CHANNELS-1:0]       IN_VALID,
  output logic [CHANNELS-1:0]       IN_READY,
  input  logic                      MODE,
  input  logic [SELW-1:0]           SEL,
  output logic [WIDTH-1:0]          O,
  output logic                      O_VALID,
  input  logic                      O_READY,
  output logic [SELW-1:0]           O_CH
);

  localparam int              c_PAD  = 1 << SELW;
  localparam logic [SELW:0]   c_CHAN = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] c_LAST = SELW'(CHANNELS - 1);

  logic [WIDTH-1:0]    r_o;
  logic                r_o_valid;
  logic [SELW-1:0]     r_o_ch;
  logic [SELW-1:0]     r_ptr;

  logic                w_load_en;
  logic                w_accept;
  logic [c_PAD-1:0]    w_valid_pad;
  logic                w_gnt_valid;
  logic [SELW-1:0]     w_gnt;
  logic [SELW:0]       w_idx;
  logic [WIDTH-1:0]    w_gnt_data;
  logic [CHANNELS-1:0] w_ready;

  assign w_load_en = !r_o_valid || O_READY;
  assign w_accept  = w_load_en && w_gnt_valid && !rst;

  // Pad valids to a power of two so any SEL value indexes safely.
  always_comb begin
    w_valid_pad                 = '0;
    w_valid_pad[CHANNELS-1:0]   = IN_VALID;
  end

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = '0;
    w_idx       = '0;
    if (!MODE) begin
      if (({1'b0, SEL} < c_CHAN) && w_valid_pad[SEL]) begin
        w_gnt_valid = 1'b1;
        w_gnt       = SEL;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        w_idx = {1'b0, r_ptr} + (SELW+1)'(k);
        if (w_idx >= c_CHAN) w_idx = w_idx - c_CHAN;
        if (!w_gnt_valid && w_valid_pad[w_idx[SELW-1:0]]) begin
          w_gnt_valid = 1'b1;
          w_gnt       = w_idx[SELW-1:0];
        end
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    w_ready    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_gnt == SELW'(i)) begin
        w_gnt_data = IN_DATA[i*WIDTH +: WIDTH];
        w_ready[i] = w_accept;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_o       <= '0;
      r_o_valid <= 1'b0;
      r_o_ch    <= '0;
      r_ptr     <= '0;
    end else if (w_load_en) begin
      if (w_gnt_valid) begin
        r_o       <= w_gnt_data;
        r_o_ch    <= w_gnt;
        r_o_valid <= 1'b1;
        if (MODE) r_ptr <= (w_gnt == c_LAST) ? '0 : w_gnt + 1'b1;
      end else begin
        r_o_valid <= 1'b0;
      end
    end
  end

  assign IN_READY = w_ready;
  assign O        = r_o;
  assign O_VALID  = r_o_valid;
  assign O_CH     = r_o_ch;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mux_rr_arb: self-checking bench for mux_rr_arb (8 and 5 channels)      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mux_rr_arb;
  localparam int W  = 16;
  localparam int C  = 8;
  localparam int SW = 3;
  localparam int C5 = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [C*W-1:0]  in_data;
  logic [C-1:0]    in_valid, in_ready;
  logic            mode, o_valid, o_ready;
  logic [SW-1:0]   sel, o_ch;
  logic [W-1:0]    o;

  logic [C5*W-1:0] d5_data;
  logic [C5-1:0]   d5_valid, d5_ready;
  logic            d5_mode, d5_ov, d5_oready;
  logic [SW-1:0]   d5_sel, d5_ch;
  logic [W-1:0]    d5_o;

  int total = 0;
  int bad   = 0;

  mux_rr_arb #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .MODE(mode), .SEL(sel), .O(o), .O_VALID(o_valid), .O_READY(o_ready), .O_CH(o_ch)
  );

  mux_rr_arb #(.WIDTH(W), .CHANNELS(C5)) dut5 (
    .clk(clk), .rst(rst), .IN_DATA(d5_data), .IN_VALID(d5_valid), .IN_READY(d5_ready),
    .MODE(d5_mode), .SEL(d5_sel), .O(d5_o), .O_VALID(d5_ov), .O_READY(d5_oready), .O_CH(d5_ch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seq_data();
    for (int i = 0; i < C; i++) in_data[i*W +: W] = 16'h1000 + 16'(i);
    for (int i = 0; i < C5; i++) d5_data[i*W +: W] = 16'h2000 + 16'(i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0; mode = 1'b0; sel = '0; o_ready = 1'b1;
    d5_valid = '0; d5_mode = 1'b0; d5_sel = '0; d5_oready = 1'b1;
    seq_data();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // First valid channel at or after p, wrapping; -1 when none.
  function automatic int rr_pick(input logic [C-1:0] v, input int p);
    for (int k = 0; k < C; k++)
      if (v[(p + k) % C]) return (p + k) % C;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 8'hFF; mode = 1'b1; sel = '0; o_ready = 1'b1;
    d5_valid = '0; d5_mode = 1'b0; d5_sel = '0; d5_oready = 1'b1;
    seq_data();
    tick();
    tick();
    total++; if (o !== 16'h0) begin bad++; $display("FAIL reset_o got=%h exp=0000", o); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%b exp=0", o_valid); end
    total++; if (o_ch !== 3'd0) begin bad++; $display("FAIL reset_och got=%0d exp=0", o_ch); end
    total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL reset_inready got=%h exp=00", in_ready); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 8'h01) begin bad++; $display("FAIL reset_first_rr_ready got=%h exp=01", in_ready); end
    tick();
    total++; if (o_ch !== 3'd0 || o !== 16'h1000 || o_valid !== 1'b1) begin
      bad++; $display("FAIL reset_first_rr_out got ch=%0d o=%h v=%b exp ch=0 o=1000 v=1", o_ch, o, o_valid);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; sel = 3'd5; in_valid = 8'h20; o_ready = 1'b1;
    in_data[5*W +: W] = 16'hA5A5;
    #1;
    total++; if (in_ready !== 8'h20) begin bad++; $display("FAIL fixed_ready got=%h exp=20", in_ready); end
    tick();
    total++; if (o !== 16'hA5A5 || o_ch !== 3'd5 || o_valid !== 1'b1) begin
      bad++; $display("FAIL fixed_out got o=%h ch=%0d v=%b exp o=a5a5 ch=5 v=1", o, o_ch, o_valid);
    end
    sel = 3'd6;
    #1;
    total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL fixed_nogrant_ready got=%h exp=00", in_ready); end
    tick();
    total++; if (o_valid !== 1'b0 || o !== 16'hA5A5 || o_ch !== 3'd5) begin
      bad++; $display("FAIL fixed_nogrant_out got v=%b o=%h ch=%0d exp v=0 o=a5a5 ch=5", o_valid, o, o_ch);
    end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    mode = 1'b1; in_valid = 8'hFF; o_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      total++; if (in_ready !== 8'(1 << (k % C))) begin
        bad++; $display("FAIL rr_ready step=%0d got=%h exp=%h", k, in_ready, 8'(1 << (k % C)));
      end
      tick();
      total++; if (o_ch !== 3'(k % C) || o !== 16'h1000 + 16'(k % C) || o_valid !== 1'b1) begin
        bad++; $display("FAIL rr_seq step=%0d got ch=%0d o=%h v=%b exp ch=%0d", k, o_ch, o, o_valid, k % C);
      end
    end
    in_valid = 8'h44;
    for (int j = 0; j < 4; j++) begin
      tick();
      total++; if (o_ch !== ((j % 2 == 0) ? 3'd2 : 3'd6) || o_valid !== 1'b1) begin
        bad++; $display("FAIL rr_alt step=%0d got ch=%0d exp=%0d", j, o_ch, (j % 2 == 0) ? 2 : 6);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1; in_valid = 8'hFF; o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL bp_ready cyc=%0d got=%h exp=00", k, in_ready); end
      tick();
      total++; if (o !== 16'h1000 || o_ch !== 3'd0 || o_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold cyc=%0d got o=%h ch=%0d v=%b exp o=1000 ch=0 v=1", k, o, o_ch, o_valid);
      end
    end
    o_ready = 1'b1;
    #1;
    total++; if (in_ready !== 8'h02) begin bad++; $display("FAIL bp_release_ready got=%h exp=02", in_ready); end
    tick();
    total++; if (o !== 16'h1001 || o_ch !== 3'd1 || o_valid !== 1'b1) begin
      bad++; $display("FAIL bp_release_out got o=%h ch=%0d v=%b exp o=1001 ch=1 v=1", o, o_ch, o_valid);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1; in_valid = 8'h08; o_ready = 1'b1;
    #1;
    total++; if (in_ready !== 8'h08) begin bad++; $display("FAIL ms_rr_ready got=%h exp=08", in_ready); end
    tick();
    total++; if (o_ch !== 3'd3) begin bad++; $display("FAIL ms_rr_ch got=%0d exp=3", o_ch); end
    mode = 1'b0; sel = 3'd1; in_valid = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (in_ready !== 8'h02) begin bad++; $display("FAIL ms_fixed_ready n=%0d got=%h exp=02", k, in_ready); end
      tick();
      total++; if (o_ch !== 3'd1 || o !== 16'h1001) begin
        bad++; $display("FAIL ms_fixed_out n=%0d got ch=%0d o=%h exp ch=1 o=1001", k, o_ch, o);
      end
    end
    mode = 1'b1;
    #1;
    total++; if (in_ready !== 8'h10) begin bad++; $display("FAIL ms_back_ready got=%h exp=10", in_ready); end
    tick();
    total++; if (o_ch !== 3'd4) begin bad++; $display("FAIL ms_back_ch got=%0d exp=4", o_ch); end
  endtask

  task automatic test_np2();
    do_reset();
    d5_mode = 1'b0; d5_sel = 3'd7; d5_valid = 5'h1F; d5_oready = 1'b1;
    #1;
    total++; if (d5_ready !== 5'h00) begin bad++; $display("FAIL np2_sel7_ready got=%h exp=00", d5_ready); end
    tick();
    total++; if (d5_ov !== 1'b0) begin bad++; $display("FAIL np2_sel7_valid got=%b exp=0", d5_ov); end
    d5_sel = 3'd4;
    #1;
    total++; if (d5_ready !== 5'h10) begin bad++; $display("FAIL np2_sel4_ready got=%h exp=10", d5_ready); end
    tick();
    total++; if (d5_ch !== 3'd4 || d5_o !== 16'h2004) begin
      bad++; $display("FAIL np2_sel4_out got ch=%0d o=%h exp ch=4 o=2004", d5_ch, d5_o);
    end
    d5_mode = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      total++; if (d5_ready !== 5'(1 << (k % C5))) begin
        bad++; $display("FAIL np2_rr_ready step=%0d got=%h exp=%h", k, d5_ready, 5'(1 << (k % C5)));
      end
      tick();
      total++; if (d5_ch !== 3'(k % C5) || d5_o !== 16'h2000 + 16'(k % C5)) begin
        bad++; $display("FAIL np2_rr_seq step=%0d got ch=%0d o=%h exp ch=%0d", k, d5_ch, d5_o, k % C5);
      end
    end
  endtask

  task automatic test_random();
    int          m_ptr, g;
    logic        m_ov, load, gv;
    logic [SW-1:0] m_ch;
    logic [C-1:0]  exp_rdy;
    logic [W-1:0]  q[$];
    logic [W-1:0]  front;
    do_reset();
    m_ptr = 0; m_ov = 1'b0; m_ch = '0;
    q.delete();
    for (int n = 0; n < 400; n++) begin
      in_valid = C'($urandom);
      mode     = 1'($urandom_range(0, 1));
      sel      = SW'($urandom_range(0, C - 1));
      o_ready  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < C; i++) in_data[i*W +: W] = W'($urandom);
      #1;
      load = !m_ov || o_ready;
      if (!mode) begin
        gv = in_valid[sel];
        g  = int'(sel);
      end else begin
        g  = rr_pick(in_valid, m_ptr);
        gv = (g >= 0);
      end
      exp_rdy = (load && gv) ? C'(1 << g) : '0;
      total++; if (in_ready !== exp_rdy) begin
        bad++; $display("FAIL rand_ready n=%0d got=%h exp=%h", n, in_ready, exp_rdy);
      end
      if (o_valid && o_ready) begin
        front = (q.size() > 0) ? q.pop_front() : 'x;
        total++; if (o !== front) begin bad++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, o, front); end
      end
      if (load) begin
        if (gv) begin
          q.push_back(in_data[g*W +: W]);
          m_ov = 1'b1;
          m_ch = SW'(g);
          if (mode) m_ptr = (g + 1) % C;
        end else begin
          m_ov = 1'b0;
        end
      end
      tick();
      total++; if (o_valid !== m_ov || (m_ov && o_ch !== m_ch)) begin
        bad++; $display("FAIL rand_out n=%0d got v=%b ch=%0d exp v=%b ch=%0d", n, o_valid, o_ch, m_ov, m_ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_fairness();
    test_backpressure();
    test_mode_switch();
    test_np2();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
